// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM states, default widths and the
// rounding/saturation helper used by the DFT datapath.
package fft_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 12;
  localparam int TW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_FLUSH,
    S_OUT,
    S_DONE
  } state_e;

  // Round half-up at bit frac, then clamp to an ow-bit signed range.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 ow
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dft_mac_engine_cmplx_mac.sv
// cmplx_mac: complex multiply feeding a registered accumulator.
// o_sum_* is the next accumulator value when enabled.
module cmplx_mac #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int ACC_W = 45
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [DW-1:0]    i_x_re,
  input  logic signed [DW-1:0]    i_x_im,
  input  logic signed [TW-1:0]    i_w_re,
  input  logic signed [TW-1:0]    i_w_im,
  output logic signed [ACC_W-1:0] o_sum_re,
  output logic signed [ACC_W-1:0] o_sum_im
);

  localparam int MW = DW + TW;
  localparam int PW = MW + 1;

  logic signed [MW-1:0]    m_rr;
  logic signed [MW-1:0]    m_ii;
  logic signed [MW-1:0]    m_ri;
  logic signed [MW-1:0]    m_ir;
  logic signed [PW-1:0]    p_re;
  logic signed [PW-1:0]    p_im;
  logic signed [ACC_W-1:0] acc_re_q;
  logic signed [ACC_W-1:0] acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q;
  logic signed [ACC_W-1:0] acc_im_d;

  always_comb begin
    m_rr = MW'(i_x_re) * MW'(i_w_re);
    m_ii = MW'(i_x_im) * MW'(i_w_im);
    m_ri = MW'(i_x_re) * MW'(i_w_im);
    m_ir = MW'(i_x_im) * MW'(i_w_re);
    p_re = PW'(m_rr) - PW'(m_ii);
    p_im = PW'(m_ri) + PW'(m_ir);
  end

  assign o_sum_re = acc_re_q + ACC_W'(p_re);
  assign o_sum_im = acc_im_q + ACC_W'(p_im);

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (i_clr) begin
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (i_en) begin
      acc_re_d = o_sum_re;
      acc_im_d = o_sum_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

endmodule

// File: rtl/dft_mac_engine.sv
// dft_mac_engine: direct DFT, one bin at a time, streaming
// samples/twiddles from 1-cycle-latency memories.
module dft_mac_engine
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic                 clk,
  input  logic                 n_Reset,
  input  logic                 i_start,
  input  logic [AW-1:0]        i_n_samples,
  output logic [AW-1:0]        o_smp_addr,
  input  logic signed [DW-1:0] i_smp_re,
  input  logic signed [DW-1:0] i_smp_im,
  output logic [AW-1:0]        o_tw_addr,
  input  logic signed [TW-1:0] i_tw_re,
  input  logic signed [TW-1:0] i_tw_im,
  output logic                 o_bin_valid,
  input  logic                 i_bin_ready,
  output logic signed [DW-1:0] o_bin_re,
  output logic signed [DW-1:0] o_bin_im,
  output logic [AW-1:0]        o_bin_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int ACC_W = DW + TW + AW + 1;

  state_e state_q, state_d;

  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] tw_q, tw_d;
  logic [AW-1:0] len_q, len_d;
  logic          v_q, v_d;
  logic          err_q, err_d;
  logic signed [DW-1:0] re_q, re_d;
  logic signed [DW-1:0] im_q, im_d;

  logic [AW:0]             tw_sum;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;

  // v_q marks a cycle whose memory data belongs to the current bin.
  cmplx_mac #(
    .DW   (DW),
    .TW   (TW),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (n_Reset),
    .i_clr   (mac_clr),
    .i_en    (v_q),
    .i_x_re  (i_smp_re),
    .i_x_im  (i_smp_im),
    .i_w_re  (i_tw_re),
    .i_w_im  (i_tw_im),
    .o_sum_re(sum_re),
    .o_sum_im(sum_im)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    tw_d    = tw_q;
    len_d   = len_q;
    v_d     = 1'b0;
    err_d   = 1'b0;
    re_d    = re_q;
    im_d    = im_q;
    mac_clr = 1'b0;
    tw_sum  = {1'b0, tw_q} + {1'b0, k_q};
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_n_samples == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_MAC;
            len_d   = i_n_samples;
            k_d     = '0;
            n_d     = '0;
            tw_d    = '0;
          end
        end
      end
      S_MAC: begin
        mac_clr = (n_q == '0);
        v_d     = 1'b1;
        if (n_q == len_q - AW'(1)) begin
          state_d = S_FLUSH;
          n_d     = '0;
          tw_d    = '0;
        end else begin
          n_d  = n_q + AW'(1);
          tw_d = AW'((tw_sum >= {1'b0, len_q}) ?
                     tw_sum - {1'b0, len_q} : tw_sum);
        end
      end
      S_FLUSH: begin
        re_d    = DW'(round_sat(64'(sum_re), TW - 1, DW));
        im_d    = DW'(round_sat(64'(sum_im), TW - 1, DW));
        state_d = S_OUT;
      end
      S_OUT: begin
        if (i_bin_ready) begin
          if (k_q == len_q - AW'(1)) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + AW'(1);
            state_d = S_MAC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_Reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      tw_q    <= '0;
      len_q   <= '0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      tw_q    <= tw_d;
      len_q   <= len_d;
      v_q     <= v_d;
      err_q   <= err_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign o_smp_addr  = (state_q == S_MAC) ? n_q : '0;
  assign o_tw_addr   = (state_q == S_MAC) ? tw_q : '0;
  assign o_bin_valid = (state_q == S_OUT);
  assign o_bin_idx   = o_bin_valid ? k_q : '0;
  assign o_bin_re    = re_q;
  assign o_bin_im    = im_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = err_q;

endmodule
